// File: rtl/clock_gen.sv
// clock_gen: timing and sequencing block for the multi-cycle RISC-V core.
// A programmable divider produces a tick every div_val+1 enabled cycles; each
// tick may step a five-phase sequencer (FETCH..WRITEBACK), subject to stall
// and single-step gating. Only single-domain enables are produced.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   en           global run enable (0 freezes divider and sequencer)
//   div_val      tick period minus one
//   stall        hold current phase, divider keeps running
//   step_mode    1 = advance only on a pending step request
//   step         step request, edge-detected internally
//   tick         one-cycle pulse per divider period
//   adv          pulse in the first cycle of a new phase
//   phase        encoded phase 0..4
//   phase_onehot bit i = (phase == i)
//   instr_done   pulse on entry to FETCH from WRITEBACK
//   instr_count  retired instructions, wraps
module clock_gen #(
  parameter int DIV_WIDTH = 8,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div_val,
  input  logic                 stall,
  input  logic                 step_mode,
  input  logic                 step,
  output logic                 tick,
  output logic                 adv,
  output logic [2:0]           phase,
  output logic [4:0]           phase_onehot,
  output logic                 instr_done,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [2:0] {
    PH_FETCH     = 3'd0,
    PH_DECODE    = 3'd1,
    PH_EXECUTE   = 3'd2,
    PH_MEMORY    = 3'd3,
    PH_WRITEBACK = 3'd4
  } phase_e;

  logic [DIV_WIDTH-1:0] r_cnt;
  phase_e               r_phase;
  logic [4:0]           r_onehot;
  logic                 r_tick;
  logic                 r_adv;
  logic                 r_done;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_step_pend;
  logic                 r_step_prev;

  logic                 w_wrap;
  logic                 w_rise;
  logic                 w_go;
  logic                 w_retire;
  phase_e               w_phase_nxt;
  logic [4:0]           w_onehot_nxt;

  // >= rather than == so a div_val lowered below cnt wraps immediately
  assign w_wrap   = en && (r_cnt >= div_val);
  assign w_rise   = step && !r_step_prev;
  // a pending step only gates the advance in step mode; it is kept otherwise
  assign w_go     = w_wrap && !stall && (!step_mode || r_step_pend);
  assign w_retire = w_go && (r_phase == PH_WRITEBACK);

  always_comb begin
    w_phase_nxt  = r_phase;
    w_onehot_nxt = r_onehot;
    if (w_go) begin
      case (r_phase)
        PH_FETCH:   w_phase_nxt = PH_DECODE;
        PH_DECODE:  w_phase_nxt = PH_EXECUTE;
        PH_EXECUTE: w_phase_nxt = PH_MEMORY;
        PH_MEMORY:  w_phase_nxt = PH_WRITEBACK;
        default:    w_phase_nxt = PH_FETCH;  // WRITEBACK and illegal 5..7
      endcase
      case (w_phase_nxt)
        PH_FETCH:     w_onehot_nxt = 5'b00001;
        PH_DECODE:    w_onehot_nxt = 5'b00010;
        PH_EXECUTE:   w_onehot_nxt = 5'b00100;
        PH_MEMORY:    w_onehot_nxt = 5'b01000;
        PH_WRITEBACK: w_onehot_nxt = 5'b10000;
        default:      w_onehot_nxt = 5'b00000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase  <= PH_FETCH;
      r_onehot <= 5'b00001;
    end else begin
      r_phase  <= w_phase_nxt;
      r_onehot <= w_onehot_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_tick      <= 1'b0;
      r_adv       <= 1'b0;
      r_done      <= 1'b0;
      r_count     <= '0;
      r_step_pend <= 1'b0;
      r_step_prev <= 1'b0;
    end else begin
      if (w_wrap)  r_cnt <= '0;
      else if (en) r_cnt <= r_cnt + 1'b1;
      r_tick      <= w_wrap;
      r_adv       <= w_go;
      r_done      <= w_retire;
      if (w_retire) r_count <= r_count + 1'b1;
      r_step_prev <= step;
      // a fresh edge wins over consumption in the same cycle
      if (w_rise)                  r_step_pend <= 1'b1;
      else if (w_go && step_mode)  r_step_pend <= 1'b0;
    end
  end

  assign tick         = r_tick;
  assign adv          = r_adv;
  assign phase        = r_phase;
  assign phase_onehot = r_onehot;
  assign instr_done   = r_done;
  assign instr_count  = r_count;

endmodule

// File: tb/tb_clock_gen.sv
module tb_clock_gen;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, en, stall, step_mode, step;
  logic [DW-1:0] div_val;
  logic          tick, adv, instr_done;
  logic [2:0]    phase;
  logic [4:0]    phase_onehot;
  logic [CW-1:0] instr_count;

  clock_gen #(.DIV_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .div_val(div_val), .stall(stall),
    .step_mode(step_mode), .step(step), .tick(tick), .adv(adv),
    .phase(phase), .phase_onehot(phase_onehot), .instr_done(instr_done),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference state: plain integers following the behavioural rules
  int m_cnt, m_phase, m_count;
  bit m_pend, m_prev, m_tick, m_adv, m_done;
  int cyc_since_rst;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit wrap, go;
    if (rst) begin
      m_cnt = 0; m_phase = 0; m_count = 0; m_pend = 0; m_prev = 0;
      m_tick = 0; m_adv = 0; m_done = 0;
      cyc_since_rst = 0;
      return;
    end
    cyc_since_rst++;
    wrap   = en && (m_cnt >= int'(div_val));
    go     = wrap && !stall && (!step_mode || m_pend);
    m_tick = wrap;
    m_adv  = go;
    m_done = go && (m_phase == 4);
    if (m_done) m_count = (m_count + 1) % (1 << CW);
    if (go) m_phase = (m_phase + 1) % 5;
    if (wrap) m_cnt = 0; else if (en) m_cnt = m_cnt + 1;
    if (step && !m_prev) m_pend = 1;
    else if (go && step_mode) m_pend = 0;
    m_prev = step;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("tick", tick, m_tick);
    chk("adv", adv, m_adv);
    chk("phase", phase, m_phase);
    chk("onehot", phase_onehot, 1 << m_phase);
    chk("done", instr_done, m_done);
    chk("count", instr_count, m_count);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  int first_tick, p0, bound;

  initial begin
    rst = 1; en = 1; div_val = 3; stall = 0; step_mode = 0; step = 0;
    run(2);
    chk("rst_phase", phase, 0);
    chk("rst_onehot", phase_onehot, 5'b00001);
    chk("rst_tick", tick, 0);
    chk("rst_count", instr_count, 0);
    rst = 0;
    // first tick must show in the 4th cycle after release
    first_tick = 0;
    for (int i = 1; i <= 8 && first_tick == 0; i++) begin
      cycle();
      if (tick) first_tick = i;
    end
    chk("first_tick_cyc", first_tick, 4);
    run(16);  // rest of the first instruction at period 4
    chk("one_instr_20cyc", instr_count, 1);

    // free-running, tick every cycle
    rst = 1; run(1); rst = 0; div_val = 0;
    run(20);
    chk("free_count4", instr_count, 4);
    run(60);
    chk("count_wrap", instr_count, 0);

    // stall while phase 2
    run(2);
    chk("pre_stall_phase", phase, 2);
    stall = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stall_tick", tick, 1);
      chk("stall_adv", adv, 0);
    end
    stall = 0;
    cycle();
    chk("unstall_phase", phase, 3);
    chk("unstall_adv", adv, 1);

    // div_val lowered below cnt
    div_val = 3;
    bound = 0;
    while (m_cnt != 2 && bound < 20) begin cycle(); bound++; end
    chk("reach_cnt2", m_cnt, 2);
    div_val = 1;
    cycle();
    chk("forced_wrap", tick, 1);
    run(6);

    // single step
    step_mode = 1; div_val = 2;
    p0 = m_phase;
    run(30);
    chk("step_hold", phase, p0);
    step = 1; cycle(); step = 0;
    run(10);
    chk("step_one", phase, (p0 + 1) % 5);
    step = 1; run(10); step = 0;
    run(10);
    chk("step_level", phase, (p0 + 2) % 5);
    step_mode = 0;

    // enable freeze
    div_val = 5; run(3);
    en = 0;
    p0 = m_phase;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("en0_tick", tick, 0);
    end
    chk("en0_phase", phase, p0);
    en = 1; run(12);

    // randomized traffic
    for (int seg = 0; seg < 300; seg++) begin
      div_val   = DW'($urandom_range(0, 4));
      en        = ($urandom_range(0, 9) != 0);
      stall     = ($urandom_range(0, 3) == 0);
      step_mode = ($urandom_range(0, 2) == 0);
      rst       = ($urandom_range(0, 60) == 0);
      for (int k = 0, n = $urandom_range(1, 12); k < n; k++) begin
        step = $urandom_range(0, 1);
        cycle();
        rst = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clock_gen.md
Name: clock_gen

Overview:
- Timing and sequencing block for the multi-cycle RISC-V core.
- Divides the system clock into a programmable tick and steps a five-phase instruction sequencer: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK.
- Drives per-phase enables to the datapath and control units, and counts retired instructions.
- Supports stall and single-step debug; no derived clocks are generated, only single-domain enables.

Parameters:
- DIV_WIDTH, 8: width of the divider compare value and counter.
- CNT_WIDTH, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  global run enable; 0 freezes divider and sequencer
- div_val  in  DIV_WIDTH  tick period minus one, in clk cycles
- stall  in  1  holds the current phase; divider keeps running
- step_mode  in  1  1 = phase advances only on a pending step request
- step  in  1  step request, level-sampled, edge-detected internally
- tick  out  1  one-cycle pulse per divider period
- adv  out  1  one-cycle pulse in the first cycle of a new phase
- phase  out  3  encoded phase: 0 FETCH, 1 DECODE, 2 EXECUTE, 3 MEMORY, 4 WRITEBACK
- phase_onehot  out  5  bit i = (phase == i)
- instr_done  out  1  one-cycle pulse on entry to FETCH from WRITEBACK
- instr_count  out  CNT_WIDTH  retired instructions, wraps modulo 2^CNT_WIDTH

Behaviour:
- All outputs are registered. rst is sampled on the clk edge and overrides every other input.
- Reset values:
  - divider counter cnt = 0
  - phase = 0 (FETCH), phase_onehot = 5'b00001
  - tick = adv = instr_done = 0
  - instr_count = 0
  - step_pending = 0, step_prev = 0
- Divider:
  - Internal wrap = en && (cnt >= div_val).
  - On wrap, cnt <= 0. Else if en, cnt <= cnt + 1. Else cnt holds.
  - tick <= wrap, so tick is high for exactly one cycle every div_val+1 cycles while en=1.
  - div_val = 0 makes tick high every cycle.
  - div_val may change at any time. The comparison is >=, so lowering div_val below cnt forces a wrap at the next edge.
- Step logic:
  - step_prev <= step on every edge.
  - A rising edge (step && !step_prev) sets step_pending.
  - step_pending clears when an advance consumes it.
  - If a new rising edge coincides with consumption, step_pending stays 1.
  - step_pending is ignored, but retained, while step_mode = 0.
- Advance condition: go = wrap && !stall && (!step_mode || step_pending).
- When go is true:
  - phase <= (phase == 4) ? 0 : phase + 1.
  - phase_onehot updates in the same edge.
- adv <= go, and is high in the first cycle of the new phase.
- instr_done <= go && (phase == 4).
- instr_count increments on the same edge that instr_done is set, wrapping at all-ones to 0.
- stall:
  - tick still pulses; adv does not; phase holds.
  - Stall asserted for any number of ticks loses no phase.
- en = 0: cnt, phase and counters freeze; tick, adv and instr_done read 0 the following cycle.
- step_mode toggled mid-period takes effect at the next wrap.
- Reset mid-phase returns to FETCH with cnt = 0 on the next cycle, discarding any pending step.
- Phase values 5–7 are unreachable. If ever present, the next go forces phase to 0.

Test Plan:
- Reset/idle: assert rst 2 cycles with en=1, div_val=3 -> phase=0, onehot=00001, tick=adv=instr_done=0, instr_count=0. Release rst -> first tick in the 4th cycle after release.
- Free-running div_val=0, en=1, 20 cycles -> tick every cycle; phase sequence 1,2,3,4,0,...; instr_done pulses each time phase enters 0; instr_count=4 after 20 advances.
- Divider div_val=3 -> tick every 4 cycles; one full instruction takes 20 cycles. Change div_val to 1 while cnt=2 -> wrap on the next edge, then period 2.
- Stall: div_val=0, hold stall=1 for 5 cycles while phase=2 -> tick high all 5 cycles, adv=0, phase stays 2. Release -> phase=3 with adv=1 next cycle.
- Single step: step_mode=1, div_val=2, no step for 30 cycles -> phase unchanged. Pulse step once -> exactly one advance at the next wrap, then hold. Holding step high for 10 cycles still yields one advance.
- Enable/counter wrap: deassert en mid-period -> cnt and phase frozen, no tick. Re-enable -> resumes from the frozen cnt. With CNT_WIDTH=4, 16 instructions -> instr_count wraps to 0.
